// File: rtl/writeback_unit.sv
// Register-file write-back merger: ALU results always win the single write port, and
// load results wait in a small FIFO that ALU writes to the same register can cancel.
module writeback_unit #(
  parameter int WIDTH        = 16,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_alu_valid,
  input  logic [2:0]       i_alu_reg_num,
  input  logic [WIDTH-1:0] i_alu_data,
  input  logic             i_ld_valid,
  output logic             o_ld_ready,
  input  logic [2:0]       i_ld_reg_num,
  input  logic [WIDTH-1:0] i_ld_data,
  input  logic             i_pc_valid,
  input  logic [WIDTH-1:0] i_pc_data,
  output logic             o_write_en,
  output logic [2:0]       o_write_register_num,
  output logic [WIDTH-1:0] o_write_register_in,
  output logic             o_pc_write_en,
  output logic [WIDTH-1:0] o_pc_register_in,
  output logic [7:0]       o_pending_mask,
  output logic             o_alu_hold
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

  logic [2:0]       r_fifo_reg  [DEPTH];
  logic [WIDTH-1:0] r_fifo_data [DEPTH];
  logic [DEPTH-1:0] r_fifo_vld;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [ST_W-1:0]  r_starve;

  logic             r_ld_ready;
  logic             r_write_en;
  logic [2:0]       r_write_num;
  logic [WIDTH-1:0] r_write_data;
  logic             r_pc_write_en;
  logic [WIDTH-1:0] r_pc_data;
  logic             r_alu_hold;

  logic             w_full;
  logic             w_empty;
  logic             w_accept;
  logic             w_head_vld;
  logic [2:0]       w_head_reg;
  logic [WIDTH-1:0] w_head_data;
  logic             w_issue;
  logic             w_pop;
  logic             w_head_cancel;
  logic             w_enq;
  logic [CNT_W-1:0] w_count_nxt;
  logic [ST_W-1:0]  w_starve_nxt;
  logic [7:0]       w_pending;

  // Handshake: a load transfers on a cycle where i_ld_valid && o_ld_ready are both high;
  // o_ld_ready depends only on registered occupancy, never on same-cycle inputs.
  always_comb begin
    w_full        = (r_count == CNT_W'(DEPTH));
    w_empty       = (r_count == '0);
    w_accept      = i_ld_valid && !w_full;
    w_head_vld    = !w_empty && r_fifo_vld[r_rd_ptr];
    w_head_reg    = r_fifo_reg[r_rd_ptr];
    w_head_data   = r_fifo_data[r_rd_ptr];
    w_issue       = w_head_vld && !i_alu_valid;
    // A cancelled head needs no write slot, so it retires even while the ALU writes.
    w_pop         = !w_empty && (!r_fifo_vld[r_rd_ptr] || !i_alu_valid);
    w_head_cancel = w_head_vld && i_alu_valid && (i_alu_reg_num == w_head_reg);
    w_enq         = w_accept && (i_ld_reg_num != 3'd0) &&
                    !(i_alu_valid && (i_alu_reg_num == i_ld_reg_num));
    w_count_nxt   = r_count + CNT_W'(w_enq) - CNT_W'(w_pop);
  end

  always_comb begin
    w_starve_nxt = r_starve;
    if (w_pop || w_head_cancel) begin
      w_starve_nxt = '0;
    end else if (w_head_vld && i_alu_valid) begin
      if (r_starve < ST_W'(STARVE_LIMIT)) begin
        w_starve_nxt = r_starve + ST_W'(1);
      end
    end
  end

  always_comb begin
    w_pending = 8'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_fifo_vld[i]) begin
        w_pending[r_fifo_reg[i]] = 1'b1;
      end
    end
  end

  // Payload storage carries no reset: only the valid bits decide what is live.
  always_ff @(posedge i_clk) begin
    if (w_enq) begin
      r_fifo_reg[r_wr_ptr]  <= i_ld_reg_num;
      r_fifo_data[r_wr_ptr] <= i_ld_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fifo_vld <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_starve   <= '0;
    end else begin
      // The ALU result is younger than every buffered load, so it kills stale ones.
      for (int i = 0; i < DEPTH; i++) begin
        if (i_alu_valid && (r_fifo_reg[i] == i_alu_reg_num)) begin
          r_fifo_vld[i] <= 1'b0;
        end
      end
      if (w_pop) begin
        r_fifo_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr             <= r_rd_ptr + PTR_W'(1);
      end
      if (w_enq) begin
        r_fifo_vld[r_wr_ptr] <= 1'b1;
        r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
      end
      r_count  <= w_count_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ld_ready    <= 1'b1;
      r_write_en    <= 1'b0;
      r_write_num   <= 3'd0;
      r_write_data  <= '0;
      r_pc_write_en <= 1'b0;
      r_pc_data     <= '0;
      r_alu_hold    <= 1'b0;
    end else begin
      if (i_alu_valid) begin
        r_write_en <= (i_alu_reg_num != 3'd0);
        if (i_alu_reg_num != 3'd0) begin
          r_write_num  <= i_alu_reg_num;
          r_write_data <= i_alu_data;
        end
      end else if (w_issue) begin
        r_write_en   <= 1'b1;
        r_write_num  <= w_head_reg;
        r_write_data <= w_head_data;
      end else begin
        r_write_en <= 1'b0;
      end
      r_pc_write_en <= i_pc_valid;
      if (i_pc_valid) begin
        r_pc_data <= i_pc_data;
      end
      r_ld_ready <= (w_count_nxt != CNT_W'(DEPTH));
      r_alu_hold <= (w_starve_nxt >= ST_W'(STARVE_LIMIT));
    end
  end

  assign o_ld_ready           = r_ld_ready;
  assign o_write_en           = r_write_en;
  assign o_write_register_num = r_write_num;
  assign o_write_register_in  = r_write_data;
  assign o_pc_write_en        = r_pc_write_en;
  assign o_pc_register_in     = r_pc_data;
  assign o_pending_mask       = w_pending;
  assign o_alu_hold           = r_alu_hold;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios then random traffic, all checked against
// a queue-based model of load buffering, cancellation, starvation and the PC path.
module tb_writeback_unit;

  localparam int WIDTH = 16;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic             clk;
  logic             rst_n;
  logic             alu_valid;
  logic [2:0]       alu_reg;
  logic [WIDTH-1:0] alu_data;
  logic             ld_valid;
  logic             ld_ready;
  logic [2:0]       ld_reg;
  logic [WIDTH-1:0] ld_data;
  logic             pc_valid;
  logic [WIDTH-1:0] pc_data;
  logic             write_en;
  logic [2:0]       write_num;
  logic [WIDTH-1:0] write_data;
  logic             pc_write_en;
  logic [WIDTH-1:0] pc_out;
  logic [7:0]       pending_mask;
  logic             alu_hold;

  writeback_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .i_alu_valid          (alu_valid),
    .i_alu_reg_num        (alu_reg),
    .i_alu_data           (alu_data),
    .i_ld_valid           (ld_valid),
    .o_ld_ready           (ld_ready),
    .i_ld_reg_num         (ld_reg),
    .i_ld_data            (ld_data),
    .i_pc_valid           (pc_valid),
    .i_pc_data            (pc_data),
    .o_write_en           (write_en),
    .o_write_register_num (write_num),
    .o_write_register_in  (write_data),
    .o_pc_write_en        (pc_write_en),
    .o_pc_register_in     (pc_out),
    .o_pending_mask       (pending_mask),
    .o_alu_hold           (alu_hold)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // reference model: program-order queue of buffered loads
  typedef struct {
    logic [2:0]       r;
    logic [WIDTH-1:0] d;
    bit               live;
  } ent_t;

  ent_t             mq[$];
  int               starve;
  logic             e_we;
  logic [2:0]       e_num;
  logic [WIDTH-1:0] e_data;
  logic             e_pcwe;
  logic [WIDTH-1:0] e_pc;
  logic             e_hold;
  int               checks;
  int               failures;

  task automatic model_reset();
    mq.delete();
    starve = 0;
    e_we = 0; e_num = 0; e_data = 0; e_pcwe = 0; e_pc = 0; e_hold = 0;
  endtask

  function automatic logic [7:0] model_mask();
    logic [7:0] m = 8'd0;
    foreach (mq[i]) if (mq[i].live) m[mq[i].r] = 1'b1;
    return m;
  endfunction

  task automatic model_cycle();
    bit               acc = ld_valid && (mq.size() < DEPTH);
    bit               issued = 0;
    bit               popped = 0;
    logic [2:0]       hr = 0;
    logic [WIDTH-1:0] hd = 0;
    if (mq.size() > 0) begin
      if (!mq[0].live) popped = 1;
      else if (!alu_valid) begin
        issued = 1; popped = 1; hr = mq[0].r; hd = mq[0].d;
      end else if (alu_reg == mq[0].r) starve = 0;
      else if (starve < LIMIT) starve++;
    end
    if (popped) begin
      void'(mq.pop_front());
      starve = 0;
    end
    if (alu_valid) begin
      e_we = (alu_reg != 0);
      if (alu_reg != 0) begin e_num = alu_reg; e_data = alu_data; end
      foreach (mq[i]) if (mq[i].r == alu_reg) mq[i].live = 0;
    end else if (issued) begin
      e_we = 1; e_num = hr; e_data = hd;
    end else begin
      e_we = 0;
    end
    if (acc && ld_reg != 0 && !(alu_valid && alu_reg == ld_reg))
      mq.push_back('{r: ld_reg, d: ld_data, live: 1'b1});
    e_hold = (starve >= LIMIT);
    e_pcwe = pc_valid;
    if (pc_valid) e_pc = pc_data;
  endtask

  // scoreboard comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic set_in(input bit av, input logic [2:0] ar, input logic [WIDTH-1:0] ad,
                        input bit lv, input logic [2:0] lr, input logic [WIDTH-1:0] ldd);
    alu_valid = av; alu_reg = ar; alu_data = ad;
    ld_valid = lv; ld_reg = lr; ld_data = ldd;
    pc_valid = 1'b0; pc_data = '0;
  endtask

  task automatic step();
    chk("ld_ready", {31'd0, ld_ready}, {31'd0, (mq.size() < DEPTH)});
    chk("pending_mask", {24'd0, pending_mask}, {24'd0, model_mask()});
    model_cycle();
    @(posedge clk); #1;
    chk("write_en", {31'd0, write_en}, {31'd0, e_we});
    chk("write_num", {29'd0, write_num}, {29'd0, e_num});
    chk("write_data", {16'd0, write_data}, {16'd0, e_data});
    chk("pc_write_en", {31'd0, pc_write_en}, {31'd0, e_pcwe});
    chk("pc_data", {16'd0, pc_out}, {16'd0, e_pc});
    chk("alu_hold", {31'd0, alu_hold}, {31'd0, e_hold});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_in(0, 0, 0, 0, 0, 0);
      step();
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"}, {31'd0, write_en}, 32'd0);
    chk({tag, "_num"}, {29'd0, write_num}, 32'd0);
    chk({tag, "_data"}, {16'd0, write_data}, 32'd0);
    chk({tag, "_pcwe"}, {31'd0, pc_write_en}, 32'd0);
    chk({tag, "_pc"}, {16'd0, pc_out}, 32'd0);
    chk({tag, "_mask"}, {24'd0, pending_mask}, 32'd0);
    chk({tag, "_hold"}, {31'd0, alu_hold}, 32'd0);
    chk({tag, "_ready"}, {31'd0, ld_ready}, 32'd1);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    model_reset();
    set_in(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // ALU only: write one cycle later, then idle
    idle(4);
    set_in(1, 3'd3, 16'h1234, 0, 0, 0);
    step();
    chk("t1_we", {31'd0, write_en}, 32'd1);
    chk("t1_data", {16'd0, write_data}, 32'h1234);
    idle(1);
    chk("t1_we_off", {31'd0, write_en}, 32'd0);

    // load behind two ALU writes
    set_in(0, 0, 0, 1, 3'd2, 16'hBEEF);
    step();
    set_in(1, 3'd4, 16'h0001, 0, 0, 0);
    step();
    chk("t2_mask", {24'd0, pending_mask}, 32'h04);
    step();
    idle(1);
    chk("t2_ld_write", {16'd0, write_data}, 32'hBEEF);
    idle(2);

    // fill the FIFO while the ALU owns the port
    set_in(1, 3'd3, 16'h0A0A, 1, 3'd1, 16'h1111);
    step();
    set_in(1, 3'd3, 16'h0B0B, 1, 3'd5, 16'h5555);
    step();
    chk("t3_full", {31'd0, ld_ready}, 32'd0);
    set_in(1, 3'd3, 16'h0C0C, 1, 3'd7, 16'h7777);
    step();
    idle(1);
    chk("t3_first", {29'd0, write_num}, 32'd1);
    chk("t3_ready_back", {31'd0, ld_ready}, 32'd1);
    idle(3);

    // ALU to the same register cancels the buffered load
    set_in(0, 0, 0, 1, 3'd6, 16'hAAAA);
    step();
    set_in(1, 3'd6, 16'h5555, 0, 0, 0);
    step();
    chk("t4_mask_clear", {24'd0, pending_mask}, 32'd0);
    idle(3);

    // starvation then an r0 ALU result
    set_in(0, 0, 0, 1, 3'd7, 16'h7E7E);
    step();
    for (int i = 0; i < 4; i++) begin
      set_in(1, 3'd3, 16'(i), 0, 0, 0);
      step();
    end
    chk("t5_hold", {31'd0, alu_hold}, 32'd1);
    set_in(1, 3'd0, 16'hFFFF, 0, 0, 0);
    step();
    chk("t5_r0", {31'd0, write_en}, 32'd0);
    idle(3);

    // asynchronous reset with two entries buffered and a write in flight
    set_in(1, 3'd2, 16'h2222, 1, 3'd1, 16'h0101);
    step();
    set_in(1, 3'd2, 16'h2323, 1, 3'd5, 16'h0505);
    pc_valid = 1'b1; pc_data = 16'h4000;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    model_reset();
    set_in(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(4);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      set_in($urandom_range(0, 99) < 45, 3'($urandom_range(0, 7)), 16'($urandom),
             $urandom_range(0, 99) < 55, 3'($urandom_range(0, 7)), 16'($urandom));
      pc_valid = $urandom_range(0, 99) < 20;
      pc_data  = 16'($urandom);
      step();
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
